matrix_io_slave: RTL

Host-facing I/O controller inside the matrix accelerator `top`. It accepts the host's X byte stream (32 bytes per matrix) into the input buffer and starts the compute core. It reports ready and finish status. It serves 18-bit results back to the host as two 9-bit halves over a `read_n`/`r_addr` read port. It is the responder to the host-side load/readback sequencer.

---
 rtl/matrix_io_pkg.sv | 23 ++
 rtl/result_readout.sv | 82 ++++++++
 rtl/matrix_io_slave.sv | 112 +++++++++++
 3 files changed

// File: rtl/matrix_io_pkg.sv
// Shared constants and state encodings for the matrix accelerator host I/O slave.
package matrix_io_pkg;

    localparam int DEF_MATRIX_NUM    = 2;
    localparam int DEF_BYTES_PER_MAT = 32;
    localparam int DEF_RES_PER_MAT   = 16;
    localparam int DEF_RES_W         = 18;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_CORE = 2'd2,
        DONE      = 2'd3
    } load_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_LO    = 2'd2,
        R_HI    = 2'd3
    } read_state_t;

endpackage

// File: rtl/result_readout.sv
// Result read port: fetches one RES_W result and returns it as two halves.
//
// state   | meaning
// R_IDLE  | waiting for read_n low; latches r_addr when it is seen
// R_FETCH | result RAM read in flight (res_rd_en high for in-range index)
// R_LO    | RAM data valid; captured, low half driven at exit
// R_HI    | high half driven at exit, then back to R_IDLE
module result_readout
    import matrix_io_pkg::*;
#(
    parameter int RES_W     = DEF_RES_W,
    parameter int RES_TOTAL = DEF_MATRIX_NUM * DEF_RES_PER_MAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_n,
    input  logic [7:0]         r_addr,
    input  logic [RES_W-1:0]   res_rd_data,
    output logic               res_rd_en,
    output logic [7:0]         res_rd_addr,
    output logic [RES_W/2-1:0] data_out
);

    localparam int         HALF_W = RES_W / 2;
    localparam logic [8:0] LIMIT  = 9'(RES_TOTAL);

    read_state_t       state;
    read_state_t       state_nxt;
    logic              in_range;
    logic              in_range_q;
    logic [HALF_W-1:0] hi_q;

    assign in_range = ({1'b0, r_addr} < LIMIT);

    // Read state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= R_IDLE;
        else      state <= state_nxt;
    end

    // Fixed four-cycle sequence once a read is accepted; read_n only matters in R_IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            R_IDLE:  if (!read_n) state_nxt = R_FETCH;
            R_FETCH: state_nxt = R_LO;
            R_LO:    state_nxt = R_HI;
            R_HI:    state_nxt = R_IDLE;
            default: state_nxt = R_IDLE;
        endcase
    end

    // RAM strobe, address latch and half-word output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_rd_en   <= 1'b0;
            res_rd_addr <= '0;
            in_range_q  <= 1'b0;
            hi_q        <= '0;
            data_out    <= '0;
        end else begin
            res_rd_en <= 1'b0;
            case (state)
                R_IDLE: begin
                    if (!read_n) begin
                        res_rd_addr <= r_addr;
                        in_range_q  <= in_range;
                        res_rd_en   <= in_range;
                    end
                end
                R_LO: begin
                    // Out-of-range reads never touched the RAM, so force both halves to zero.
                    data_out <= in_range_q ? res_rd_data[HALF_W-1:0] : '0;
                    hi_q     <= in_range_q ? res_rd_data[RES_W-1:HALF_W] : '0;
                end
                R_HI: data_out <= hi_q;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/matrix_io_slave.sv
// Host-facing I/O slave: loads X bytes into the input buffer, kicks the
// compute core, reports ready/finish and serves results via result_readout.
// MATRIX_NUM and BYTES_PER_MAT are powers of two so {mat_idx, byte_cnt} is dense.
//
// state     | meaning
// IDLE      | ready for a load request
// LOAD      | writing one byte per valid_input cycle
// WAIT_CORE | core started, waiting for core_done
// DONE      | matrix finished, ready for the next load request
module matrix_io_slave
    import matrix_io_pkg::*;
#(
    parameter int MATRIX_NUM    = DEF_MATRIX_NUM,
    parameter int BYTES_PER_MAT = DEF_BYTES_PER_MAT,
    parameter int RES_PER_MAT   = DEF_RES_PER_MAT,
    parameter int RES_W         = DEF_RES_W,
    localparam int MI_W         = (MATRIX_NUM > 1) ? $clog2(MATRIX_NUM) : 1,
    localparam int BC_W         = $clog2(BYTES_PER_MAT),
    localparam int ADDR_W       = MI_W + BC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_in,
    input  logic               valid_input,
    input  logic [7:0]         X_load,
    input  logic               read_n,
    input  logic [7:0]         r_addr,
    output logic [RES_W/2-1:0] data_out,
    output logic               ry,
    output logic               finish,
    output logic               x_wr_en,
    output logic [ADDR_W-1:0]  x_wr_addr,
    output logic [7:0]         x_wr_data,
    output logic               mat_go,
    input  logic               core_done,
    output logic               res_rd_en,
    output logic [7:0]         res_rd_addr,
    input  logic [RES_W-1:0]   res_rd_data
);

    load_state_t     state;
    load_state_t     state_nxt;
    logic [BC_W-1:0] byte_cnt;
    logic [MI_W-1:0] mat_idx;
    logic            last_wr;
    logic            byte_last;
    logic            wr_now;

    assign byte_last = (byte_cnt == BC_W'(BYTES_PER_MAT - 1));
    assign wr_now    = (state == LOAD) && valid_input;
    assign ry        = (state == IDLE) || (state == DONE);
    assign finish    = (state == DONE);

    // Load state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Load sequencing; core_done has priority in WAIT_CORE because start_in is not looked at there.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_in) state_nxt = LOAD;
            LOAD:      if (wr_now && byte_last) state_nxt = WAIT_CORE;
            WAIT_CORE: if (core_done) state_nxt = DONE;
            DONE:      if (start_in) state_nxt = LOAD;
            default:   state_nxt = IDLE;
        endcase
    end

    // Registered buffer write, byte/matrix counters and the delayed core start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_wr_en   <= 1'b0;
            x_wr_addr <= '0;
            x_wr_data <= '0;
            byte_cnt  <= '0;
            mat_idx   <= '0;
            last_wr   <= 1'b0;
            mat_go    <= 1'b0;
        end else begin
            x_wr_en <= wr_now;
            last_wr <= wr_now && byte_last;
            mat_go  <= last_wr;
            if (wr_now) begin
                x_wr_addr <= {mat_idx, byte_cnt};
                x_wr_data <= X_load;
                byte_cnt  <= byte_last ? '0 : byte_cnt + 1'b1;
            end
            if (ry && start_in) byte_cnt <= '0;
            if (state == WAIT_CORE && core_done) begin
                mat_idx <= (mat_idx == MI_W'(MATRIX_NUM - 1)) ? '0 : mat_idx + 1'b1;
            end
        end
    end

    result_readout #(
        .RES_W     (RES_W),
        .RES_TOTAL (MATRIX_NUM * RES_PER_MAT)
    ) u_readout (
        .clk         (clk),
        .rst         (rst),
        .read_n      (read_n),
        .r_addr      (r_addr),
        .res_rd_data (res_rd_data),
        .res_rd_en   (res_rd_en),
        .res_rd_addr (res_rd_addr),
        .data_out    (data_out)
    );

endmodule
